// File: rtl/pl_reg_elastic.sv
// pl_reg_elastic: two-entry elastic pipeline register with whole-stage flush and per-thread squash.
// Define PL_REG_STATS_EN to add the stall_count/drop_count statistics outputs.
module pl_reg_elastic #(
    parameter int PAYLOAD_WIDTH = 108,
    parameter int BITS_THREADS  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     kill_valid,
    input  logic [BITS_THREADS-1:0]  kill_tid,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BITS_THREADS-1:0]  in_tid,
    input  logic [PAYLOAD_WIDTH-1:0] in_payload,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BITS_THREADS-1:0]  out_tid,
    output logic [PAYLOAD_WIDTH-1:0] out_payload,
    output logic [1:0]               occupancy
`ifdef PL_REG_STATS_EN
    ,
    output logic [31:0]              stall_count,
    output logic [31:0]              drop_count
`endif
);
    logic                     skid_valid;
    logic [BITS_THREADS-1:0]  skid_tid;
    logic [PAYLOAD_WIDTH-1:0] skid_payload;
    logic accept, pop, main_match, skid_match, in_match;
    logic main_keep, skid_keep, in_keep, nm_valid, ns_valid;
    logic [BITS_THREADS-1:0]  nm_tid, ns_tid;
    logic [PAYLOAD_WIDTH-1:0] nm_payload, ns_payload;

    assign in_ready  = !skid_valid;
    assign occupancy = {1'b0, out_valid} + {1'b0, skid_valid};

    // Survivors are packed in order: retained main, then skid, then the incoming beat.
    always_comb begin
        accept     = in_valid & in_ready;
        pop        = out_valid & out_ready;
        main_match = kill_valid & (out_tid == kill_tid);
        skid_match = kill_valid & (skid_tid == kill_tid);
        in_match   = kill_valid & (in_tid == kill_tid);
        main_keep  = out_valid & !pop & !main_match;
        skid_keep  = skid_valid & !skid_match;
        in_keep    = accept & !in_match;
        nm_valid   = main_keep | skid_keep | in_keep;
        nm_tid     = main_keep ? out_tid : skid_keep ? skid_tid : in_tid;
        nm_payload = main_keep ? out_payload : skid_keep ? skid_payload : in_payload;
        ns_valid   = main_keep & (skid_keep | in_keep);
        ns_tid     = skid_keep ? skid_tid : in_tid;
        ns_payload = skid_keep ? skid_payload : in_payload;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_tid      <= '0;
            out_payload  <= '0;
            skid_valid   <= 1'b0;
            skid_tid     <= '0;
            skid_payload <= '0;
        end else begin
            out_valid  <= nm_valid & !clr;
            skid_valid <= ns_valid & !clr;
            if (nm_valid) begin
                out_tid     <= nm_tid;
                out_payload <= nm_payload;
            end
            if (ns_valid) begin
                skid_tid     <= ns_tid;
                skid_payload <= ns_payload;
            end
        end
    end

`ifdef PL_REG_STATS_EN
    logic [1:0] drops;
    // A popped main beat counts as delivered even under clr or kill.
    always_comb begin
        drops = {1'b0, out_valid & !pop & (clr | main_match)}
              + {1'b0, skid_valid & (clr | skid_match)}
              + {1'b0, accept & (clr | in_match)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            drop_count  <= '0;
        end else begin
            stall_count <= stall_count + {31'd0, out_valid & !out_ready};
            drop_count  <= drop_count + {30'd0, drops};
        end
    end
`endif
endmodule
